// File: rtl/ps2_mouse_pkg.sv
// Shared types and protocol constants for the PS/2 mouse controller.
// Covers the controller state encoding, the movement packet layout and a coordinate clamp helper.
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    ST_SEND_RST,
    ST_WAIT_TX_RST,
    ST_ACK_RST,
    ST_BAT,
    ST_ID,
    ST_SEND_EN,
    ST_WAIT_TX_EN,
    ST_ACK_EN,
    ST_B0,
    ST_B1,
    ST_B2
  } state_t;

  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic       sync;
    logic [2:0] btn;
  } pkt_b0_t;

  typedef struct packed {
    pkt_b0_t    b0;
    logic [7:0] x;
    logic [7:0] y;
  } pkt_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic signed [11:0] lim);
    if (v < 0)        return '0;
    else if (v > lim) return lim[9:0];
    else              return v[9:0];
  endfunction

endpackage

// File: rtl/mouse_cursor_accum.sv
// Cursor accumulator: applies one signed packet delta per update and clamps to the screen.
// Screen y grows downward while PS/2 y grows upward, hence the subtraction on y.
module mouse_cursor_accum
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned MAX_X = 639,
  parameter int unsigned MAX_Y = 479
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_upd,
  input  logic [8:0] i_dx,
  input  logic [8:0] i_dy,
  input  logic       i_x_ovf,
  input  logic       i_y_ovf,
  output logic [9:0] o_cursor_x,
  output logic [9:0] o_cursor_y
);

  localparam logic signed [11:0] LIM_X = 12'(MAX_X);
  localparam logic signed [11:0] LIM_Y = 12'(MAX_Y);

  logic [9:0]         r_x, r_y;
  logic signed [11:0] w_dx, w_dy, w_nx, w_ny;

  always_comb begin
    w_dx = i_x_ovf ? 12'sd0 : {{3{i_dx[8]}}, i_dx};
    w_dy = i_y_ovf ? 12'sd0 : {{3{i_dy[8]}}, i_dy};
    w_nx = $signed({2'b00, r_x}) + w_dx;
    w_ny = $signed({2'b00, r_y}) - w_dy;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_upd) begin
      r_x <= clamp_coord(w_nx, LIM_X);
      r_y <= clamp_coord(w_ny, LIM_Y);
    end
  end

  assign o_cursor_x = r_x;
  assign o_cursor_y = r_y;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: reset/enable handshake with retry, then 3-byte stream packet decode.
// Feeds decoded deltas to the cursor accumulator; never writes ps2tx once streaming.
module ps2_mouse_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES     = 25_000_000,
  parameter int unsigned PKT_TIMEOUT_CYCLES = 500_000,
  parameter int unsigned MAX_X              = 639,
  parameter int unsigned MAX_Y              = 479
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx_wr,
  output logic [7:0] tx_din,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       ready,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic [3:0] init_retries
);

  localparam int unsigned T_MAX = (TIMEOUT_CYCLES > PKT_TIMEOUT_CYCLES) ?
                                  TIMEOUT_CYCLES : PKT_TIMEOUT_CYCLES;
  localparam int TW = $clog2(T_MAX + 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_tx_wr, r_ready, r_pkt_valid;
  logic [7:0]    r_tx_din, r_x;
  logic [2:0]    r_btn;
  logic [8:0]    r_dx, r_dy;
  logic [3:0]    r_init_retries;
  pkt_b0_t       r_b0;

  pkt_t          w_pkt;
  state_t        w_next;
  logic [7:0]    w_expect;
  logic          w_init_to, w_pkt_to, w_init_fail, w_upd;

  // The Y byte is consumed straight from rx_dout so the packet decodes in its arrival cycle.
  assign w_pkt     = '{b0: r_b0, x: r_x, y: rx_dout};
  assign w_init_to = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_pkt_to  = (r_timer == TW'(PKT_TIMEOUT_CYCLES - 1));
  assign w_upd     = (r_state == ST_B2) && rx_done_tick && w_pkt.b0.sync;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_expect    = RSP_ACK;
    w_next      = ST_SEND_RST;
    w_init_fail = 1'b0;
    case (r_state)
      ST_WAIT_TX_RST: begin w_next = ST_ACK_RST; w_init_fail = !tx_done_tick && w_init_to; end
      ST_ACK_RST:     begin w_expect = RSP_ACK;    w_next = ST_BAT;     end
      ST_BAT:         begin w_expect = RSP_BAT_OK; w_next = ST_ID;      end
      ST_ID:          begin w_expect = RSP_ID;     w_next = ST_SEND_EN; end
      ST_WAIT_TX_EN:  begin w_next = ST_ACK_EN; w_init_fail = !tx_done_tick && w_init_to; end
      ST_ACK_EN:      begin w_expect = RSP_ACK;    w_next = ST_B0;      end
      default: ;
    endcase
    if (r_state inside {ST_ACK_RST, ST_BAT, ST_ID, ST_ACK_EN})
      w_init_fail = rx_done_tick ? (rx_dout != w_expect) : w_init_to;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_SEND_RST;
      r_timer        <= '0;
      r_tx_wr        <= 1'b0;
      r_tx_din       <= '0;
      r_ready        <= 1'b0;
      r_pkt_valid    <= 1'b0;
      r_btn          <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_init_retries <= '0;
      r_b0           <= '0;
      r_x            <= '0;
    end else begin
      r_tx_wr     <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_timer     <= r_timer + 1'b1;
      if (w_init_fail) begin
        r_state <= ST_SEND_RST;
        r_timer <= '0;
        if (r_init_retries != 4'hF) r_init_retries <= r_init_retries + 1'b1;
      end else begin
        case (r_state)
          ST_SEND_RST, ST_SEND_EN: begin
            r_timer <= '0;
            if (tx_idle) begin
              r_tx_wr  <= 1'b1;
              r_tx_din <= (r_state == ST_SEND_RST) ? CMD_RESET : CMD_ENABLE;
              r_state  <= (r_state == ST_SEND_RST) ? ST_WAIT_TX_RST : ST_WAIT_TX_EN;
            end
          end
          ST_WAIT_TX_RST, ST_WAIT_TX_EN: begin
            if (tx_done_tick) begin
              r_state <= w_next;
              r_timer <= '0;
            end
          end
          ST_ACK_RST, ST_BAT, ST_ID, ST_ACK_EN: begin
            if (rx_done_tick) begin
              r_state <= w_next;
              r_timer <= '0;
              if (r_state == ST_ACK_EN) r_ready <= 1'b1;
            end
          end
          ST_B0: begin
            r_timer <= '0;
            if (rx_done_tick && rx_dout[3]) begin
              r_b0    <= pkt_b0_t'(rx_dout);
              r_state <= ST_B1;
            end
          end
          ST_B1: begin
            if (rx_done_tick) begin
              r_x     <= rx_dout;
              r_state <= ST_B2;
              r_timer <= '0;
            end else if (w_pkt_to) begin
              r_state <= ST_B0;
              r_timer <= '0;
            end
          end
          ST_B2: begin
            if (rx_done_tick) begin
              r_state <= ST_B0;
              r_timer <= '0;
              if (w_pkt.b0.sync) begin
                r_pkt_valid <= 1'b1;
                r_btn       <= w_pkt.b0.btn;
                r_dx        <= {w_pkt.b0.x_sign, w_pkt.x};
                r_dy        <= {w_pkt.b0.y_sign, w_pkt.y};
              end
            end else if (w_pkt_to) begin
              r_state <= ST_B0;
              r_timer <= '0;
            end
          end
          default: begin
            r_state <= ST_SEND_RST;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  mouse_cursor_accum #(.MAX_X(MAX_X), .MAX_Y(MAX_Y)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .i_upd     (w_upd),
    .i_dx      ({w_pkt.b0.x_sign, w_pkt.x}),
    .i_dy      ({w_pkt.b0.y_sign, w_pkt.y}),
    .i_x_ovf   (w_pkt.b0.x_ovf),
    .i_y_ovf   (w_pkt.b0.y_ovf),
    .o_cursor_x(cursor_x),
    .o_cursor_y(cursor_y)
  );

  assign tx_wr        = r_tx_wr;
  assign tx_din       = r_tx_din;
  assign ready        = r_ready;
  assign pkt_valid    = r_pkt_valid;
  assign btn          = r_btn;
  assign dx           = r_dx;
  assign dy           = r_dy;
  assign init_retries = r_init_retries;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: init handshake, retries/timeouts, packet decode and cursor clamping.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ps2_mouse_ctrl;

  localparam int TO    = 100;
  localparam int PTO   = 50;
  localparam int MAXX  = 639;
  localparam int MAXY  = 479;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_idle = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       tx_wr, ready, pkt_valid;
  logic [7:0] tx_din;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic [9:0] cursor_x, cursor_y;
  logic [3:0] init_retries;

  int n_cmp  = 0;
  int n_fail = 0;
  int mx = 0, my = 0;

  typedef struct {
    logic [7:0] b0, x, y;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    int         cx, cy;
  } vec_t;
  vec_t tbl[$];

  ps2_mouse_ctrl #(.TIMEOUT_CYCLES(TO), .PKT_TIMEOUT_CYCLES(PTO), .MAX_X(MAXX), .MAX_Y(MAXY)) dut (
    .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_din(tx_din), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .ready(ready), .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .init_retries(init_retries)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic pv);
    rx_dout = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    pv = pkt_valid;
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] cmd, input int budget, output int waited);
    waited = 0;
    while (!tx_wr && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("tx_wr strobe", 32'(tx_wr), 1);
    if (tx_wr) check("tx_din", 32'(tx_din), 32'(cmd));
    @(negedge clk);
    check("tx_wr one cycle", 32'(tx_wr), 0);
  endtask

  task automatic finish_init();
    logic pv;
    int   w;
    send_byte(8'hFA, pv);
    send_byte(8'hAA, pv);
    send_byte(8'h00, pv);
    check("ready low during init", 32'(ready), 0);
    expect_tx(8'hF4, 20, w);
    pulse_tx_done();
    send_byte(8'hFA, pv);
    check("ready after ACK_EN", 32'(ready), 1);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: PS/2 packet semantics in integer arithmetic.
  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] x, input logic [7:0] y,
                           output logic [2:0] e_btn, output logic [8:0] e_dx, output logic [8:0] e_dy);
    int dxv, dyv;
    dxv = b0[4] ? int'(x) - 256 : int'(x);
    dyv = b0[5] ? int'(y) - 256 : int'(y);
    if (!b0[6]) mx = clampi(mx + dxv, MAXX);
    if (!b0[7]) my = clampi(my - dyv, MAXY);
    e_btn = b0[2:0];
    e_dx  = 9'(dxv);
    e_dy  = 9'(dyv);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] x, input logic [7:0] y,
                          input int gap, input logic [2:0] e_btn, input logic [8:0] e_dx,
                          input logic [8:0] e_dy, input int e_cx, input int e_cy);
    logic pv;
    send_byte(b0, pv);
    check("no pulse after b0", 32'(pv), 0);
    idle(gap);
    send_byte(x, pv);
    check("no pulse after x", 32'(pv), 0);
    idle(gap);
    send_byte(y, pv);
    check("pkt_valid", 32'(pv), 1);
    check("btn", 32'(btn), 32'(e_btn));
    if (!b0[6]) check("dx", 32'(dx), 32'(e_dx));
    if (!b0[7]) check("dy", 32'(dy), 32'(e_dy));
    check("cursor_x", 32'(cursor_x), 32'(e_cx));
    check("cursor_y", 32'(cursor_y), 32'(e_cy));
    idle(1);
    check("pkt_valid one cycle", 32'(pkt_valid), 0);
  endtask

  initial begin
    logic       pv;
    int         w, seen;
    logic [2:0] e_btn;
    logic [8:0] e_dx, e_dy;
    logic [7:0] rb0, rx, ry;

    tbl.push_back('{8'h29, 8'h05, 8'hFE, 3'b001, 9'h005, 9'h1FE,   5,   2});
    tbl.push_back('{8'h18, 8'hFD, 8'h02, 3'b000, 9'h1FD, 9'h002,   2,   0});
    tbl.push_back('{8'h18, 8'hF0, 8'h00, 3'b000, 9'h1F0, 9'h000,   0,   0});
    tbl.push_back('{8'h49, 8'h7F, 8'h00, 3'b001, 9'h07F, 9'h000,   0,   0});
    tbl.push_back('{8'h2A, 8'h64, 8'h9C, 3'b010, 9'h064, 9'h19C, 100, 100});
    tbl.push_back('{8'h0C, 8'hFF, 8'h00, 3'b100, 9'h0FF, 9'h000, 355, 100});
    tbl.push_back('{8'h0C, 8'hFF, 8'h00, 3'b100, 9'h0FF, 9'h000, 610, 100});
    tbl.push_back('{8'h0C, 8'hFF, 8'h00, 3'b100, 9'h0FF, 9'h000, 639, 100});
    tbl.push_back('{8'h88, 8'h01, 8'h50, 3'b000, 9'h001, 9'h050, 639, 100});
    tbl.push_back('{8'h28, 8'h00, 8'h00, 3'b000, 9'h000, 9'h100, 639, 356});
    tbl.push_back('{8'h28, 8'h00, 8'h00, 3'b000, 9'h000, 9'h100, 639, 479});

    // Reset values.
    idle(3);
    check("rst tx_wr", 32'(tx_wr), 0);
    check("rst tx_din", 32'(tx_din), 0);
    check("rst ready", 32'(ready), 0);
    check("rst pkt_valid", 32'(pkt_valid), 0);
    check("rst btn", 32'(btn), 0);
    check("rst dx", 32'(dx), 0);
    check("rst dy", 32'(dy), 0);
    check("rst cursor_x", 32'(cursor_x), 0);
    check("rst cursor_y", 32'(cursor_y), 0);
    check("rst init_retries", 32'(init_retries), 0);

    // Command must wait for the transmitter to go idle.
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_wr) seen++;
    end
    check("no tx_wr while busy", 32'(seen), 0);
    tx_idle = 1'b1;

    // Nominal init.
    expect_tx(8'hFF, 10, w);
    pulse_tx_done();
    finish_init();
    check("retries after clean init", 32'(init_retries), 0);

    // Table-driven packets from cursor (0,0).
    foreach (tbl[i]) begin
      model_pkt(tbl[i].b0, tbl[i].x, tbl[i].y, e_btn, e_dx, e_dy);
      send_pkt(tbl[i].b0, tbl[i].x, tbl[i].y, 0, tbl[i].btn, tbl[i].dx, tbl[i].dy,
               tbl[i].cx, tbl[i].cy);
    end

    // Stray byte without sync bit is discarded.
    send_byte(8'h05, pv);
    check("stray byte no pulse", 32'(pv), 0);
    idle(2);
    check("stray byte still no pulse", 32'(pkt_valid), 0);

    // Partial packet dropped after inter-byte silence.
    send_byte(8'h08, pv);
    idle(PTO + 5);
    check("timeout no pulse", 32'(pkt_valid), 0);
    model_pkt(8'h08, 8'h01, 8'h01, e_btn, e_dx, e_dy);
    send_pkt(8'h08, 8'h01, 8'h01, 0, 3'b000, 9'h001, 9'h001, 639, 478);

    // Random packets with occasional stray bytes and short gaps.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_byte(8'($urandom) & 8'hF7, pv);
        check("random stray no pulse", 32'(pv), 0);
      end
      rb0 = 8'($urandom) | 8'h08;
      rx  = 8'($urandom);
      ry  = 8'($urandom);
      model_pkt(rb0, rx, ry, e_btn, e_dx, e_dy);
      send_pkt(rb0, rx, ry, $urandom_range(0, 3), e_btn, e_dx, e_dy, mx, my);
    end

    // Reset in the middle of a packet.
    send_byte(8'h08, pv);
    rst = 1'b1;
    idle(2);
    check("midrst ready", 32'(ready), 0);
    check("midrst cursor_x", 32'(cursor_x), 0);
    check("midrst cursor_y", 32'(cursor_y), 0);
    check("midrst btn", 32'(btn), 0);
    mx = 0;
    my = 0;
    rst = 1'b0;

    // Bad BAT byte restarts init; a byte while awaiting tx_done is ignored.
    expect_tx(8'hFF, 10, w);
    pulse_tx_done();
    send_byte(8'hFA, pv);
    send_byte(8'hFC, pv);
    expect_tx(8'hFF, 10, w);
    check("retries after bad BAT", 32'(init_retries), 1);
    send_byte(8'hFA, pv);
    pulse_tx_done();
    finish_init();
    check("retries after recovery", 32'(init_retries), 1);

    // Init response timeout.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    expect_tx(8'hFF, 10, w);
    pulse_tx_done();
    expect_tx(8'hFF, 3 * TO, w);
    check("timeout window", 32'(w >= TO && w <= TO + 3), 1);
    check("retries after timeout", 32'(init_retries), 1);

    // Retry counter saturates.
    for (int i = 0; i < 16; i++) begin
      pulse_tx_done();
      send_byte(8'h00, pv);
      expect_tx(8'hFF, 10, w);
      if (i == 0) check("retries count 2", 32'(init_retries), 2);
    end
    check("retries saturate", 32'(init_retries), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
